core_spi_responder: RTL and testbench

- SPI slave (mode 0, MSB first) on the core side of the core/IO SPI link.
- Answers the master's frame-fetch protocol: SETPTR (0x07) followed by an 8-bit argument, and READNEXT (0x04) followed by a dummy byte.
- On READNEXT it returns the byte at a read pointer in the channel buffer on MISO, then auto-increments the pointer.
- Sits between the core's channel RAM (synchronous read) and the SPI pins.

---
 rtl/core_spi_responder.sv | 166 ++++++++++++++++
 tb/tb_core_spi_responder.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_spi_responder.sv
// Core-side SPI responder (mode 0, MSB first). It serves the SETPTR / READNEXT fetch
// protocol from the channel RAM through an auto-incrementing, wrapping read pointer.
module core_spi_responder #(
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned DEPTH        = 480,
    parameter logic [7:0]  CMD_SETPTR   = 8'h07,
    parameter logic [7:0]  CMD_READNEXT = 8'h04
) (
    input  logic              clk_in,
    input  logic              n_reset,
    input  logic              spi_sck,
    input  logic              spi_n_ss,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              bad_cmd
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StArg,
        StFetch,
        StLoad,
        StData,
        StIgnore
    } state_e;

    state_e            state_q;
    logic [1:0]        sck_sync_q;
    logic [1:0]        ss_sync_q;
    logic [1:0]        mosi_sync_q;
    logic              sck_prev_q;
    logic              ss_prev_q;
    logic [6:0]        rx_shift_q;
    logic [7:0]        tx_shift_q;
    logic [2:0]        bit_cnt_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_rd_q;
    logic              bad_cmd_q;

    logic       sck_rise;
    logic       sck_fall;
    logic       ss_high;
    logic       ss_fall;
    logic       mosi_s;
    logic       byte_done;
    logic [7:0] rx_byte;

    always_comb begin
        sck_rise  = sck_sync_q[1] & ~sck_prev_q;
        sck_fall  = ~sck_sync_q[1] & sck_prev_q;
        ss_high   = ss_sync_q[1];
        ss_fall   = ~ss_sync_q[1] & ss_prev_q;
        mosi_s    = mosi_sync_q[1];
        byte_done = sck_rise && (bit_cnt_q == 3'd7);
        rx_byte   = {rx_shift_q, mosi_s};
    end

    always_ff @(posedge clk_in) begin
        if (!n_reset) begin
            state_q     <= StIdle;
            sck_sync_q  <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            rd_ptr_q    <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            bad_cmd_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], spi_sck};
            ss_sync_q   <= {ss_sync_q[0], spi_n_ss};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            sck_prev_q  <= sck_sync_q[1];
            ss_prev_q   <= ss_sync_q[1];
            mem_rd_q    <= 1'b0;
            bad_cmd_q   <= 1'b0;

            if (ss_high) begin
                state_q    <= StIdle;
                bit_cnt_q  <= '0;
                tx_shift_q <= '0;
            end else if (ss_fall) begin
                state_q    <= StCmd;
                bit_cnt_q  <= '0;
                rx_shift_q <= '0;
                tx_shift_q <= '0;
            end else begin
                if (sck_rise) begin
                    rx_shift_q <= rx_byte[6:0];
                    bit_cnt_q  <= bit_cnt_q + 3'd1;
                end
                // The first fall of a byte must not shift, or a freshly loaded MSB is lost.
                if (sck_fall && (bit_cnt_q != 3'd0)) begin
                    tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                end

                unique case (state_q)
                    StIdle: ;
                    StCmd: begin
                        if (byte_done) begin
                            if (rx_byte == CMD_SETPTR) begin
                                state_q <= StArg;
                            end else if (rx_byte == CMD_READNEXT) begin
                                // Strobe is registered on entry so it is high exactly in FETCH.
                                state_q    <= StFetch;
                                mem_addr_q <= rd_ptr_q;
                                mem_rd_q   <= 1'b1;
                            end else begin
                                bad_cmd_q <= 1'b1;
                                state_q   <= StIgnore;
                            end
                        end
                    end
                    StArg: begin
                        if (byte_done) begin
                            if ({24'd0, rx_byte} >= DEPTH) begin
                                rd_ptr_q <= '0;
                            end else begin
                                rd_ptr_q <= ADDR_W'(rx_byte);
                            end
                            state_q <= StIgnore;
                        end
                    end
                    StFetch: begin
                        if (rd_ptr_q == ADDR_W'(DEPTH - 1)) begin
                            rd_ptr_q <= '0;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                        end
                        state_q <= StLoad;
                    end
                    StLoad: begin
                        tx_shift_q <= mem_data;
                        state_q    <= StData;
                    end
                    StData: begin
                        if (byte_done) begin
                            state_q <= StIgnore;
                        end
                    end
                    StIgnore: begin
                        tx_shift_q <= '0;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign spi_miso = tx_shift_q[7];
    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;
    assign rd_ptr   = rd_ptr_q;
    assign bad_cmd  = bad_cmd_q;

endmodule

// File: tb/tb_core_spi_responder.sv
// Bench for core_spi_responder: an SPI master drives two responders (DEPTH 480 and 200)
// and results are compared against a pointer/RAM model of the fetch protocol.
module tb_core_spi_responder;

    localparam int HALF    = 8;
    localparam int DEPTH_A = 480;
    localparam int DEPTH_B = 200;

    logic       clk_in = 1'b0;
    logic       n_reset;
    logic       spi_sck;
    logic       spi_mosi;
    logic       ss_a;
    logic       ss_b;
    logic       miso_a;
    logic       miso_b;
    logic [8:0] addr_a;
    logic [8:0] addr_b;
    logic [8:0] ptr_a;
    logic [8:0] ptr_b;
    logic       rd_a;
    logic       rd_b;
    logic       bad_a;
    logic       bad_b;
    logic [7:0] data_a;
    logic [7:0] data_b;

    logic [7:0] ram [2][DEPTH_A];
    int         model_ptr [2];
    int         rd_cnt [2];
    int         bad_cnt [2];
    logic [8:0] last_addr [2];
    int         checks = 0;
    int         errors = 0;

    always #5 clk_in = ~clk_in;

    core_spi_responder u_dut_a (
        .clk_in   (clk_in),
        .n_reset  (n_reset),
        .spi_sck  (spi_sck),
        .spi_n_ss (ss_a),
        .spi_mosi (spi_mosi),
        .spi_miso (miso_a),
        .mem_addr (addr_a),
        .mem_rd   (rd_a),
        .mem_data (data_a),
        .rd_ptr   (ptr_a),
        .bad_cmd  (bad_a)
    );

    core_spi_responder #(.DEPTH(DEPTH_B)) u_dut_b (
        .clk_in   (clk_in),
        .n_reset  (n_reset),
        .spi_sck  (spi_sck),
        .spi_n_ss (ss_b),
        .spi_mosi (spi_mosi),
        .spi_miso (miso_b),
        .mem_addr (addr_b),
        .mem_rd   (rd_b),
        .mem_data (data_b),
        .rd_ptr   (ptr_b),
        .bad_cmd  (bad_b)
    );

    // Synchronous-read channel RAMs.
    always @(posedge clk_in) begin
        if (rd_a) data_a <= ram[0][addr_a];
        if (rd_b) data_b <= ram[1][addr_b];
    end

    always @(negedge clk_in) begin
        if (rd_a) begin
            rd_cnt[0]    <= rd_cnt[0] + 1;
            last_addr[0] <= addr_a;
        end
        if (rd_b) begin
            rd_cnt[1]    <= rd_cnt[1] + 1;
            last_addr[1] <= addr_b;
        end
        if (bad_a) bad_cnt[0] <= bad_cnt[0] + 1;
        if (bad_b) bad_cnt[1] <= bad_cnt[1] + 1;
    end

    function automatic int depth_of(input bit sel);
        return sel ? DEPTH_B : DEPTH_A;
    endfunction

    function automatic logic [8:0] cur_ptr(input bit sel);
        return sel ? ptr_b : ptr_a;
    endfunction

    function automatic void model_setptr(input bit sel, input logic [7:0] arg);
        model_ptr[sel] = (int'(arg) >= depth_of(sel)) ? 0 : int'(arg);
    endfunction

    function automatic logic [7:0] model_readnext(input bit sel);
        logic [7:0] d;
        d = ram[sel][model_ptr[sel]];
        model_ptr[sel] = (model_ptr[sel] + 1) % depth_of(sel);
        return d;
    endfunction

    task automatic ss_drive(input bit sel, input logic v);
        if (sel) ss_b = v;
        else     ss_a = v;
    endtask

    task automatic spi_xfer(input bit sel, input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            spi_mosi = tx[7-k];
            repeat (HALF) @(negedge clk_in);
            rx[7-k] = sel ? miso_b : miso_a;
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clk_in);
            spi_sck = 1'b0;
        end
    endtask

    task automatic start_frame(input bit sel);
        ss_drive(sel, 1'b0);
        repeat (4) @(negedge clk_in);
    endtask

    task automatic end_frame(input bit sel);
        repeat (HALF) @(negedge clk_in);
        ss_drive(sel, 1'b1);
        repeat (6) @(negedge clk_in);
    endtask

    task automatic frame(input bit sel, input logic [7:0] b0, input logic [7:0] b1,
                         output logic [7:0] r0, output logic [7:0] r1);
        start_frame(sel);
        spi_xfer(sel, b0, 8, r0);
        spi_xfer(sel, b1, 8, r1);
        end_frame(sel);
    endtask

    task automatic test_reset();
        n_reset  = 1'b0;
        ss_a     = 1'b1;
        ss_b     = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        repeat (4) @(posedge clk_in);
        @(negedge clk_in);
        checks++;
        if (miso_a !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", miso_a); end
        checks++;
        if (addr_a !== 9'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", addr_a); end
        checks++;
        if (rd_a !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got %b want 0", rd_a); end
        checks++;
        if (ptr_a !== 9'd0) begin errors++; $display("FAIL reset_ptr got %0d want 0", ptr_a); end
        checks++;
        if (bad_a !== 1'b0) begin errors++; $display("FAIL reset_bad got %b want 0", bad_a); end
        checks++;
        if ({miso_b, addr_b, rd_b, ptr_b, bad_b} !== 21'd0) begin
            errors++;
            $display("FAIL reset_b outputs got %h want 0", {miso_b, addr_b, rd_b, ptr_b, bad_b});
        end
        n_reset = 1'b1;
        model_ptr[0] = 0;
        model_ptr[1] = 0;
        repeat (6) @(negedge clk_in);
    endtask

    task automatic test_setptr();
        logic [7:0] arg, r0, r1;
        int         rd0;
        for (int i = 0; i < 5; i++) begin
            arg = (i == 0) ? 8'h05 : 8'($urandom_range(0, 255));
            rd0 = rd_cnt[0];
            frame(1'b0, 8'h07, arg, r0, r1);
            model_setptr(1'b0, arg);
            checks++;
            if (ptr_a !== 9'(model_ptr[0])) begin
                errors++;
                $display("FAIL setptr_ptr arg %h got %0d want %0d", arg, ptr_a, model_ptr[0]);
            end
            checks++;
            if ({r0, r1} !== 16'h0000 || rd_cnt[0] != rd0) begin
                errors++;
                $display("FAIL setptr_quiet miso %h reads %0d want 0000 and 0",
                         {r0, r1}, rd_cnt[0] - rd0);
            end
        end
    endtask

    task automatic test_readnext();
        logic [7:0] arg, r0, r1, exp;
        int         rd0, exp_addr;
        ram[0][5] = 8'hA5;
        for (int i = 0; i < 7; i++) begin
            arg = (i == 0) ? 8'h05 : 8'($urandom_range(0, 255));
            // Every other iteration chains a second read from the auto-incremented pointer.
            if (i % 2 == 0) begin
                frame(1'b0, 8'h07, arg, r0, r1);
                model_setptr(1'b0, arg);
            end
            rd0      = rd_cnt[0];
            exp_addr = model_ptr[0];
            exp      = model_readnext(1'b0);
            frame(1'b0, 8'h04, 8'($urandom), r0, r1);
            checks++;
            if (r1 !== exp || r0 !== 8'h00) begin
                errors++;
                $display("FAIL readnext_data addr %0d got %h/%h want 00/%h", exp_addr, r0, r1, exp);
            end
            checks++;
            if (ptr_a !== 9'(model_ptr[0])) begin
                errors++;
                $display("FAIL readnext_ptr got %0d want %0d", ptr_a, model_ptr[0]);
            end
            checks++;
            if (rd_cnt[0] - rd0 != 1 || last_addr[0] !== 9'(exp_addr)) begin
                errors++;
                $display("FAIL readnext_strobe count %0d addr %0d want 1 and %0d",
                         rd_cnt[0] - rd0, last_addr[0], exp_addr);
            end
        end
    endtask

    task automatic test_bad_cmd();
        logic [7:0] opc, r0, r1;
        int         bad0, rd0, p0;
        for (int i = 0; i < 3; i++) begin
            opc = 8'h55;
            if (i > 0) begin
                do opc = 8'($urandom); while (opc == 8'h07 || opc == 8'h04);
            end
            bad0 = bad_cnt[0];
            rd0  = rd_cnt[0];
            p0   = model_ptr[0];
            frame(1'b0, opc, 8'hFF, r0, r1);
            checks++;
            if (bad_cnt[0] - bad0 != 1) begin
                errors++;
                $display("FAIL bad_cmd_pulse opc %h got %0d cycles want 1", opc, bad_cnt[0] - bad0);
            end
            checks++;
            if (ptr_a !== 9'(p0) || {r0, r1} !== 16'h0000 || rd_cnt[0] != rd0) begin
                errors++;
                $display("FAIL bad_cmd_quiet ptr %0d miso %h reads %0d want %0d 0000 0",
                         ptr_a, {r0, r1}, rd_cnt[0] - rd0, p0);
            end
        end
    endtask

    task automatic test_clamp();
        logic [7:0] r0, r1, arg;
        frame(1'b1, 8'h07, 8'd50, r0, r1);
        model_setptr(1'b1, 8'd50);
        checks++;
        if (ptr_b !== 9'd50) begin errors++; $display("FAIL clamp_inrange got %0d want 50", ptr_b); end
        frame(1'b1, 8'h07, 8'hF0, r0, r1);
        model_setptr(1'b1, 8'hF0);
        checks++;
        if (ptr_b !== 9'd0) begin errors++; $display("FAIL clamp_f0 got %0d want 0", ptr_b); end
        frame(1'b1, 8'h07, 8'd77, r0, r1);
        arg = 8'($urandom_range(DEPTH_B, 255));
        frame(1'b1, 8'h07, arg, r0, r1);
        model_setptr(1'b1, arg);
        checks++;
        if (ptr_b !== 9'(model_ptr[1])) begin
            errors++;
            $display("FAIL clamp_random arg %0d got %0d want %0d", arg, ptr_b, model_ptr[1]);
        end
    endtask

    task automatic test_abort();
        logic [7:0] r0, r1, exp;
        int         p0;
        p0 = model_ptr[0];
        start_frame(1'b0);
        spi_xfer(1'b0, 8'h07, 8, r0);
        spi_xfer(1'b0, 8'($urandom), 4, r1);
        end_frame(1'b0);
        checks++;
        if (ptr_a !== 9'(p0)) begin
            errors++;
            $display("FAIL abort_ptr got %0d want %0d", ptr_a, p0);
        end
        exp = model_readnext(1'b0);
        frame(1'b0, 8'h04, 8'h00, r0, r1);
        checks++;
        if (r1 !== exp || ptr_a !== 9'(model_ptr[0])) begin
            errors++;
            $display("FAIL abort_recover got %h ptr %0d want %h ptr %0d",
                     r1, ptr_a, exp, model_ptr[0]);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] r0, r1, exp;
        int         rd0;
        logic [7:0] dummy;
        frame(1'b0, 8'h07, 8'd255, r0, r1);
        model_setptr(1'b0, 8'd255);
        rd0 = rd_cnt[0];
        // Command-only frames: the pointer advances even though the data byte is never clocked.
        for (int i = 0; i < DEPTH_A - 1 - 255; i++) begin
            start_frame(1'b0);
            spi_xfer(1'b0, 8'h04, 8, r0);
            end_frame(1'b0);
            dummy = model_readnext(1'b0);
        end
        checks++;
        if (ptr_a !== 9'(model_ptr[0]) || rd_cnt[0] - rd0 != DEPTH_A - 1 - 255) begin
            errors++;
            $display("FAIL wrap_walk ptr %0d reads %0d want %0d and %0d",
                     ptr_a, rd_cnt[0] - rd0, model_ptr[0], DEPTH_A - 1 - 255);
        end
        ram[0][DEPTH_A-1] = 8'h3C;
        for (int s = 0; s < 2; s++) begin
            if (s == 1) begin
                frame(1'b1, 8'h07, 8'(DEPTH_B - 1), r0, r1);
                model_setptr(1'b1, 8'(DEPTH_B - 1));
            end
            for (int j = 0; j < 2; j++) begin
                exp = model_readnext(1'(s));
                frame(1'(s), 8'h04, 8'h00, r0, r1);
                checks++;
                if (r1 !== exp || cur_ptr(1'(s)) !== 9'(model_ptr[s])) begin
                    errors++;
                    $display("FAIL wrap_read dut %0d step %0d got %h ptr %0d want %h ptr %0d",
                             s, j, r1, cur_ptr(1'(s)), exp, model_ptr[s]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_data();
        logic [7:0] r0, r1, exp;
        frame(1'b0, 8'h07, 8'd30, r0, r1);
        model_setptr(1'b0, 8'd30);
        ram[0][30] = 8'hFF;
        start_frame(1'b0);
        spi_xfer(1'b0, 8'h04, 8, r0);
        spi_xfer(1'b0, 8'h00, 3, r1);
        n_reset = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        checks++;
        if ({miso_a, addr_a, rd_a, ptr_a, bad_a} !== 21'd0) begin
            errors++;
            $display("FAIL reset_mid_data miso %b addr %0d rd %b ptr %0d bad %b want all 0",
                     miso_a, addr_a, rd_a, ptr_a, bad_a);
        end
        checks++;
        if (ptr_b !== 9'd0) begin
            errors++;
            $display("FAIL reset_mid_data_b ptr got %0d want 0", ptr_b);
        end
        n_reset = 1'b1;
        model_ptr[0] = 0;
        model_ptr[1] = 0;
        end_frame(1'b0);
        exp = model_readnext(1'b0);
        frame(1'b0, 8'h04, 8'h00, r0, r1);
        checks++;
        if (r1 !== exp || ptr_a !== 9'(model_ptr[0])) begin
            errors++;
            $display("FAIL reset_recover got %h ptr %0d want %h ptr %0d",
                     r1, ptr_a, exp, model_ptr[0]);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH_A; i++) ram[s][i] = 8'($urandom);
        end
        test_reset();
        test_setptr();
        test_readnext();
        test_bad_cmd();
        test_clamp();
        test_abort();
        test_wrap();
        test_reset_mid_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
